// File: rtl/bayer_pkg.sv
// Shared types and helpers for the Bayer re-mosaic path.
package bayer_pkg;

  typedef logic [7:0] pix_t;

  typedef struct packed {
    pix_t r;
    pix_t g1;
    pix_t g2;
    pix_t b;
  } quad_t;

  // 2x2 raster window, top row first
  typedef struct packed {
    pix_t tl;
    pix_t tr;
    pix_t bl;
    pix_t br;
  } window_t;

  typedef enum logic {
    TOP = 1'b0,
    BOT = 1'b1
  } mosaic_state_t;

  localparam logic [1:0] PH_RGGB = 2'b00;
  localparam logic [1:0] PH_GRBG = 2'b01;
  localparam logic [1:0] PH_GBRG = 2'b10;
  localparam logic [1:0] PH_BGGR = 2'b11;

  // Place the colour samples of a quad into the window according to CFA phase
  function automatic window_t quad_to_window(input quad_t q, input logic [1:0] ph);
    window_t w;
    case (ph)
      PH_RGGB: w = '{tl: q.r,  tr: q.g1, bl: q.g2, br: q.b};
      PH_GRBG: w = '{tl: q.g1, tr: q.r,  bl: q.b,  br: q.g2};
      PH_GBRG: w = '{tl: q.g1, tr: q.b,  bl: q.r,  br: q.g2};
      default: w = '{tl: q.b,  tr: q.g1, bl: q.g2, br: q.r};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bayer_line_buf.sv
// Half-line buffer: holds {BL, BR} of each block until the bottom row is emitted.
module bayer_line_buf #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Write port; contents need no reset since every entry is written before it is read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bayer_mosaic.sv
// Rebuilds a raster Bayer stream from per-block colour quads, one pixel per beat.
module bayer_mosaic
  import bayer_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_row,
  input  logic       cfg_col,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g1,
  input  logic [7:0] in_g2,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pix,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int unsigned NBC = WIDTH / 2;
  localparam int unsigned NBR = HEIGHT / 2;
  localparam int unsigned BCW = (NBC > 1) ? $clog2(NBC) : 1;
  localparam int unsigned BRW = (NBR > 1) ? $clog2(NBR) : 1;

  mosaic_state_t  state;
  logic [BCW-1:0] bcol;
  logic [BRW-1:0] brow;
  logic           half;
  logic           pend_valid;
  pix_t           pend_reg;
  logic [1:0]     phase_q;

  logic           can_load;
  logic           accept;
  logic           first_blk;
  logic           last_col;
  logic           last_row;
  logic [1:0]     phase_eff;
  quad_t          quad;
  window_t        win;
  logic [15:0]    lb_rdata;

  // Handshake and position decode
  assign can_load  = !out_valid || out_ready;
  assign in_ready  = !rst && (state == TOP) && !pend_valid && can_load;
  assign accept    = in_valid && in_ready;
  assign first_blk = (state == TOP) && (bcol == '0) && (brow == '0);
  assign last_col  = (bcol == BCW'(NBC - 1));
  assign last_row  = (brow == BRW'(NBR - 1));

  // The frame's first quad uses the live cfg so the latch takes effect immediately
  assign phase_eff = first_blk ? {cfg_row, cfg_col} : phase_q;
  assign quad      = '{r: in_r, g1: in_g1, g2: in_g2, b: in_b};
  assign win       = quad_to_window(quad, phase_eff);

  bayer_line_buf #(
    .DEPTH (NBC),
    .AW    (BCW)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (bcol),
    .wdata ({win.bl, win.br}),
    .raddr (bcol),
    .rdata (lb_rdata)
  );

  // Sequencer: top row straight from quads, bottom row replayed from the line buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TOP;
      bcol       <= '0;
      brow       <= '0;
      half       <= 1'b0;
      pend_valid <= 1'b0;
      pend_reg   <= '0;
      phase_q    <= 2'b00;
      out_valid  <= 1'b0;
      out_pix    <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
    end else if (can_load) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      case (state)
        TOP: begin
          if (pend_valid) begin
            out_valid  <= 1'b1;
            out_pix    <= pend_reg;
            out_eol    <= last_col;
            pend_valid <= 1'b0;
            if (last_col) begin
              bcol  <= '0;
              half  <= 1'b0;
              state <= BOT;
            end else begin
              bcol <= bcol + BCW'(1);
            end
          end else if (accept) begin
            if (first_blk) begin
              phase_q <= {cfg_row, cfg_col};
            end
            out_valid  <= 1'b1;
            out_pix    <= win.tl;
            out_sof    <= first_blk;
            pend_reg   <= win.tr;
            pend_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b1;
          if (!half) begin
            out_pix <= lb_rdata[15:8];
            half    <= 1'b1;
          end else begin
            out_pix <= lb_rdata[7:0];
            half    <= 1'b0;
            out_eol <= last_col;
            out_eof <= last_col && last_row;
            if (last_col) begin
              bcol  <= '0;
              brow  <= last_row ? '0 : brow + BRW'(1);
              state <= TOP;
            end else begin
              bcol <= bcol + BCW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Directed bench for bayer_mosaic on a 4x2 frame.
module tb_bayer_mosaic;
  import bayer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_row, cfg_col;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r, in_g1, in_g2, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pix;
  logic       out_sof, out_eol, out_eof;

  int n_checks = 0;
  int n_errors = 0;

  quad_t       q_list [$];
  logic [1:0]  cfg_list [$];
  logic [10:0] got [$];

  // Hand-derived pixel order for quads {10,11,12,13},{20,21,22,23}, indexed by phase
  logic [7:0] exp_seq [4][8] = '{
    '{8'd10, 8'd11, 8'd20, 8'd21, 8'd12, 8'd13, 8'd22, 8'd23},
    '{8'd11, 8'd10, 8'd21, 8'd20, 8'd13, 8'd12, 8'd23, 8'd22},
    '{8'd11, 8'd13, 8'd21, 8'd23, 8'd10, 8'd12, 8'd20, 8'd22},
    '{8'd13, 8'd11, 8'd23, 8'd21, 8'd12, 8'd10, 8'd22, 8'd20}
  };

  bayer_mosaic #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_row   (cfg_row),
    .cfg_col   (cfg_col),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g1     (in_g1),
    .in_g2     (in_g2),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  // Sideband {sof, eol, eof} expected at pixel index i of 8-pixel frames
  function automatic logic [2:0] sb_of(input int i);
    return {(i % 8) == 0, (i % 4) == 3, (i % 8) == 7};
  endfunction

  task automatic load_frame(input logic [1:0] c0, input logic [1:0] c1);
    q_list.push_back(quad_t'{8'd10, 8'd11, 8'd12, 8'd13});
    cfg_list.push_back(c0);
    q_list.push_back(quad_t'{8'd20, 8'd21, 8'd22, 8'd23});
    cfg_list.push_back(c1);
  endtask

  // Feed queued quads and collect nexp pixels; optional 1,0,0,1 out_ready pattern
  task automatic run_stream(input int nexp, input bit bp);
    int qi = 0;
    int acc = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_word = '0;
    got.delete();
    while (got.size() < nexp && cyc < 2000) begin
      @(posedge clk); #1;
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (qi < q_list.size()) begin
        in_valid = 1'b1;
        {in_r, in_g1, in_g2, in_b} = q_list[qi];
        {cfg_row, cfg_col} = cfg_list[qi];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_pix, out_sof, out_eol, out_eof} !== {1'b1, prev_word}) begin
          n_errors++;
          $display("FAIL hold_stable cyc%0d got %h required %h", cyc,
                   {out_valid, out_pix, out_sof, out_eol, out_eof}, {1'b1, prev_word});
        end
      end
      if (in_ready && acc > 0 && (acc % 2) == 0) begin
        n_checks++;
        if (got.size() < 4 * acc - 1) begin
          n_errors++;
          $display("FAIL in_ready_bot cyc%0d in_ready=1 with %0d pixels out, required >= %0d",
                   cyc, got.size(), 4 * acc - 1);
        end
      end
      if (in_valid && in_ready) begin
        qi++;
        acc++;
      end
      if (out_valid && out_ready) got.push_back({out_pix, out_sof, out_eol, out_eof});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_pix, out_sof, out_eol, out_eof};
      cyc++;
    end
    if (cyc >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout got %0d pixels required %0d", got.size(), nexp);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q_list.delete();
    cfg_list.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_row = 1'b0; cfg_col = 1'b0;
    in_r = '0; in_g1 = '0; in_g2 = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_pix, out_sof, out_eol, out_eof} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h required 0",
               {in_ready, out_valid, out_pix, out_sof, out_eol, out_eof});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_phase(input logic [1:0] ph);
    logic [10:0] w, e;
    load_frame(ph, ph);
    run_stream(8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      w = (i < got.size()) ? got[i] : 'x;
      e = {exp_seq[ph][i], sb_of(i)};
      n_checks++;
      if (w !== e) begin
        n_errors++;
        $display("FAIL phase%0d pix%0d got %h required %h", ph, i, w, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] w, e;
    load_frame(2'b00, 2'b00);
    run_stream(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      w = (i < got.size()) ? got[i] : 'x;
      e = {exp_seq[0][i], sb_of(i)};
      n_checks++;
      if (w !== e) begin
        n_errors++;
        $display("FAIL backpressure pix%0d got %h required %h", i, w, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] w, e;
    load_frame(2'b00, 2'b00);
    run_stream(3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_pix, out_sof, out_eol, out_eof} !== 13'd0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs got %h required 0",
               {in_ready, out_valid, out_pix, out_sof, out_eol, out_eof});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_frame(2'b00, 2'b00);
    run_stream(8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      w = (i < got.size()) ? got[i] : 'x;
      e = {exp_seq[0][i], sb_of(i)};
      n_checks++;
      if (w !== e) begin
        n_errors++;
        $display("FAIL after_reset pix%0d got %h required %h", i, w, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] w, e;
    load_frame(2'b00, 2'b01);
    load_frame(2'b01, 2'b01);
    run_stream(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      w = (i < got.size()) ? got[i] : 'x;
      e = {(i < 8) ? exp_seq[0][i] : exp_seq[1][i - 8], sb_of(i)};
      n_checks++;
      if (w !== e) begin
        n_errors++;
        $display("FAIL back_to_back pix%0d got %h required %h", i, w, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_phase(2'b00);
    test_phase(2'b11);
    test_phase(2'b01);
    test_phase(2'b10);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bayer_mosaic.md
Name: bayer_mosaic

Overview:
- Re-mosaics per-block colour quads {R, G1, G2, B} back into a raster Bayer pixel stream, one 8-bit pixel per beat.
- It is the write-back/transmit counterpart of the RGGB demux. The demux splits a 2x2 window by CFA phase; this block rebuilds the 2x2 window from the quad and serialises it line by line.
- A half-line buffer holds bottom-row pixels until the top row of the block-row has been emitted.
- Sits between the colour-processing pipeline and the raw-frame output/memory writer.

Parameters:
- WIDTH, 640, pixels per line; must be even and at least 4.
- HEIGHT, 480, lines per frame; must be even and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_row  input  1  CFA row phase of the frame's top-left pixel; sampled at the first accepted quad of a frame.
- cfg_col  input  1  CFA column phase; sampled together with cfg_row.
- in_valid  input  1  quad valid.
- in_ready  output  1  quad accepted on the cycle where in_valid && in_ready.
- in_r  input  8  red sample.
- in_g1  input  8  green sample 1.
- in_g2  input  8  green sample 2.
- in_b  input  8  blue sample.
- out_valid  output  1  pixel valid.
- out_ready  input  1  downstream accepts the pixel.
- out_pix  output  8  Bayer pixel.
- out_sof  output  1  first pixel of frame.
- out_eol  output  1  last pixel of a line.
- out_eof  output  1  last pixel of frame.

Behaviour:
- Reset values: all outputs 0. State is TOP; counters and pend_valid are 0; latched phase is 00. Reset mid-frame discards all buffered data and restarts at the next quad.
- Quad to window mapping, using the latched phase (row, col), window order TL, TR, BL, BR:
  - phase 00: R, G1, G2, B.
  - phase 01: G1, R, B, G2.
  - phase 10: G1, B, R, G2.
  - phase 11: B, G1, G2, R.
- Counters: bcol from 0 to WIDTH/2-1 (block column); brow from 0 to HEIGHT/2-1 (block row).
- State TOP:
  - in_ready = !pend_valid && (!out_valid || out_ready).
  - On accept: the output register loads TL next cycle (1-cycle latency) and out_valid=1. TR is stored in pend_reg and pend_valid=1. {BL, BR} is written to line-buffer entry bcol.
  - When out_pix is consumed and pend_valid=1: the output loads TR and pend_valid clears.
  - Throughput: one quad per 2 cycles with out_ready held high.
  - After TR of bcol = WIDTH/2-1 is loaded into the output: bcol returns to 0 and the state goes to BOT.
- State BOT:
  - in_ready = 0.
  - Reads line-buffer entry bcol and emits BL, then BR, one per output handshake.
  - After BR of the last entry is loaded: bcol returns to 0 and brow increments.
  - If brow wraps from HEIGHT/2-1 to 0, the frame ends. The state then returns to TOP.
- Sideband is registered alongside out_pix:
  - out_sof=1 with TL when brow=0 and bcol=0.
  - out_eol=1 with the TR of the last block in TOP, and with the BR of the last entry in BOT.
  - out_eof=1 together with out_eol on the final BR of the frame.
- Output stability: while out_valid && !out_ready, out_pix and all sideband hold stable.
- Phase latch: cfg_row and cfg_col are latched on the accept with brow=0, bcol=0, state TOP. Changes mid-frame have no effect.
- Simultaneous consume and load: when out_ready is high on a cycle that also loads a new pixel, the new pixel replaces the old with no bubble.
- Line-buffer read/write ordering: BOT reads only entries already written, and TOP writes only after BOT has finished. No read/write collision handling is required.

Decomposition:
- Package bayer_pkg:
  - typedef pix_t as logic [7:0].
  - typedef quad_t as a packed struct {r, g1, g2, b}.
  - enum mosaic_state_t {TOP, BOT}.
  - Phase constants PH_RGGB=2'b00, PH_GRBG=2'b01, PH_GBRG=2'b10, PH_BGGR=2'b11.
- Sub-module bayer_line_buf:
  - depth WIDTH/2, 16-bit entries, one write port and one asynchronous read port.
  - register array; no reset on contents.

Test Plan:
- WIDTH=4, HEIGHT=2, phase 00, out_ready=1. Quads {R,G1,G2,B} = {10,11,12,13}, then {20,21,22,23}. Required output: 10,11,20,21,12,13,22,23. sof on the first pixel; eol on the 4th and 8th pixels; eof on the 8th.
- Same quads with phase 11. Required output: 13,11,23,21,12,10,22,20.
- Phase 01, then phase 10, same quads:
  - phase 01: 11,10,21,20,13,12,23,22.
  - phase 10: 11,13,21,23,10,12,20,22.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly. Required: out_pix and sideband held while stalled, no pixel lost or duplicated, in_ready=0 throughout BOT.
- Reset asserted after the 3rd output pixel. Required: outputs 0 during reset. A new frame of the same quads then produces the full 8-pixel sequence from sof.
- Two back-to-back frames, with cfg_col changed mid-frame 1. Required: frame 1 keeps its latched phase; frame 2 uses the new phase; sof appears on pixel 9.
